// File: rtl/Pipe_Buf_Reg_PKG.sv
// Shared types for the instruction fetch queue: fetch FSM states and the
// queue entry layout at the default PC/instruction widths.
package Pipe_Buf_Reg_PKG;

  localparam int FQ_PC_W  = 9;
  localparam int FQ_INS_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [FQ_PC_W-1:0]  pc;
    logic [FQ_INS_W-1:0] instr;
  } fq_entry;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer holding fetched {pc, instr} entries; flush empties it in one
// clock. Callers never push when full or pop when empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 41
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;

  // Storage is cleared on reset so the head reads as zero before any push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues in-order fetches, drops responses that
// belong to a squashed path, and buffers good instructions for IF/ID.
module fetch_queue
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int PC_W  = FQ_PC_W,
  parameter int INS_W = FQ_INS_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_valid,
  input  logic [INS_W-1:0] imem_rdata,
  output logic             out_valid,
  output logic [PC_W-1:0]  out_pc,
  output logic [INS_W-1:0] out_instr,
  input  logic             out_ready,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  input  logic             halt
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e     state_r;
  fetch_state_e     state_s;
  logic [PC_W-1:0]  fetch_pc_r;
  logic [1:0]       outstanding_r;
  logic [1:0]       outstanding_s;
  logic [1:0]       drop_cnt_r;
  logic [CW-1:0]    count_s;
  logic             issue_s;
  logic             push_s;
  logic             pop_s;
  logic [PC_W-1:0]  resp_pc_s;
  logic [PC_W+INS_W-1:0] head_s;

  // Outstanding includes responses already marked for dropping, so the
  // occupancy test below reserves queue space for every in-flight word.
  assign issue_s = (state_r == S_RUN) && !halt && !redirect &&
                   (outstanding_r < 2'd2) &&
                   ((int'(count_s) + int'(outstanding_r)) < DEPTH);

  assign push_s = imem_valid && (drop_cnt_r == 2'd0) && !redirect;
  assign pop_s  = out_valid && out_ready && !redirect;

  // With nothing left to drop, the oldest live request sits outstanding*4 behind fetch_pc.
  assign resp_pc_s     = fetch_pc_r - PC_W'({outstanding_r, 2'b00});
  assign outstanding_s = outstanding_r + {1'b0, issue_s} - {1'b0, imem_valid};

  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: state_s = S_RUN;
      S_RUN: begin
        if (halt && !redirect) state_s = S_HALT;
        else                   state_s = S_RUN;
      end
      S_HALT: begin
        if (redirect) state_s = S_RUN;
        else          state_s = S_HALT;
      end
      default: state_s = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= S_IDLE;
      fetch_pc_r    <= '0;
      outstanding_r <= 2'd0;
      drop_cnt_r    <= 2'd0;
    end else begin
      state_r       <= state_s;
      outstanding_r <= outstanding_s;
      if (redirect) begin
        fetch_pc_r <= redirect_pc;
        drop_cnt_r <= outstanding_s;
      end else begin
        if (issue_s) begin
          fetch_pc_r <= fetch_pc_r + PC_W'(4);
        end
        if (imem_valid && (drop_cnt_r != 2'd0)) begin
          drop_cnt_r <= drop_cnt_r - 2'd1;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PC_W + INS_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({resp_pc_s, imem_rdata}),
    .rdata (head_s),
    .count (count_s)
  );

  assign imem_req  = issue_s;
  assign imem_addr = fetch_pc_r;
  assign out_valid = (count_s != '0);
  assign out_pc    = head_s[PC_W+INS_W-1:INS_W];
  assign out_instr = head_s[INS_W-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised and directed bench for fetch_queue against a queue-based
// reference model and an in-order latency>=1 instruction memory.
module tb_fetch_queue;

  localparam int PC_W  = 9;
  localparam int INS_W = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_valid;
  logic [INS_W-1:0] imem_rdata;
  logic             out_valid;
  logic [PC_W-1:0]  out_pc;
  logic [INS_W-1:0] out_instr;
  logic             out_ready;
  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;
  logic             halt;

  always #5 clk = ~clk;

  fetch_queue #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_ready   (out_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt)
  );

  typedef struct {
    logic [PC_W-1:0] pc;
    bit              drop;
  } flight_t;

  flight_t         inflight[$];
  logic [PC_W-1:0] ref_q[$];
  logic [PC_W-1:0] mem_q[$];
  logic [PC_W-1:0] deliv[$];
  int              m_state;
  logic [PC_W-1:0] m_pc;
  int n_checks, n_pass;
  int cyc, req_cnt, first_req, first_val, req_mark;

  function automatic logic [INS_W-1:0] mem_word(input logic [PC_W-1:0] a);
    return {7'h2B, a, ~a[7:0], a[7:0]};
  endfunction

  function automatic logic [31:0] dget(input int i);
    if (i < deliv.size()) return 32'(deliv[i]);
    else return 32'hFFFF_FFFF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    imem_valid = 1'b0; imem_rdata = '0; out_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    inflight.delete(); ref_q.delete(); mem_q.delete(); deliv.delete();
    m_state = 0; m_pc = '0; cyc = 0;
    req_cnt = 0; first_req = -1; first_val = -1;
    repeat (2) @(negedge clk);
    check_eq("rst_imem_req",  32'(imem_req),  32'd0);
    check_eq("rst_imem_addr", 32'(imem_addr), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_pc",    32'(out_pc),    32'd0);
    check_eq("rst_out_instr", 32'(out_instr), 32'd0);
    reset = 1'b1;
  endtask

  // One clock: drive at the negedge, check just after, update model at posedge.
  task automatic step(input bit rdy, input bit rd, input logic [PC_W-1:0] rpc,
                      input bit hl, input bit ret);
    logic            exp_req, obs_req, resp;
    logic [PC_W-1:0] obs_addr;
    flight_t         f;
    out_ready = rdy; redirect = rd; redirect_pc = rpc; halt = hl;
    resp = ret && (mem_q.size() != 0);
    imem_valid = resp;
    imem_rdata = resp ? mem_word(mem_q[0]) : INS_W'($urandom);
    #1;
    exp_req = (m_state == 1) && !hl && !rd &&
              ((ref_q.size() + inflight.size()) < DEPTH) && (inflight.size() < 2);
    check_eq("imem_req",  32'(imem_req),  32'(exp_req));
    check_eq("imem_addr", 32'(imem_addr), 32'(m_pc));
    check_eq("out_valid", 32'(out_valid), 32'(ref_q.size() != 0));
    if (ref_q.size() != 0) begin
      check_eq("out_pc",    32'(out_pc),    32'(ref_q[0]));
      check_eq("out_instr", 32'(out_instr), 32'(mem_word(ref_q[0])));
    end
    obs_req  = imem_req;
    obs_addr = imem_addr;
    if (obs_req) begin
      req_cnt++;
      if (first_req < 0) first_req = cyc;
    end
    if (out_valid && first_val < 0) first_val = cyc;
    if (out_valid && rdy && !rd) deliv.push_back(out_pc);
    @(posedge clk);
    if (rd) begin
      ref_q.delete();
      if (resp && inflight.size() != 0) void'(inflight.pop_front());
      foreach (inflight[i]) inflight[i].drop = 1'b1;
      m_pc = rpc;
    end else begin
      if (ref_q.size() != 0 && rdy) void'(ref_q.pop_front());
      if (resp && inflight.size() != 0) begin
        f = inflight.pop_front();
        if (!f.drop) ref_q.push_back(f.pc);
      end
      if (exp_req) begin
        inflight.push_back('{m_pc, 1'b0});
        m_pc = m_pc + 9'd4;
      end
    end
    case (m_state)
      0:       m_state = 1;
      1:       if (hl && !rd) m_state = 2;
      2:       if (rd) m_state = 1;
      default: m_state = 0;
    endcase
    if (resp) void'(mem_q.pop_front());
    if (obs_req) mem_q.push_back(obs_addr);
    if (rd) deliv.delete();
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    // Latency-1 memory, consumer always ready.
    do_reset();
    repeat (10) step(1, 0, '0, 0, 1);
    check_eq("s1_latency", 32'(first_val - first_req), 32'd2);
    for (int i = 0; i < 4; i++) check_eq("s1_pc_seq", dget(i), 32'(4 * i));

    // Consumer stalled: queue fills to DEPTH and fetching stops.
    do_reset();
    repeat (12) step(0, 0, '0, 0, 1);
    check_eq("s2_req_cnt", 32'(req_cnt), 32'd4);
    check_eq("s2_no_req",  32'(imem_req), 32'd0);
    repeat (6) step(1, 0, '0, 0, 1);
    for (int i = 0; i < 4; i++) check_eq("s2_pc_seq", dget(i), 32'(4 * i));

    // Redirect with two requests outstanding.
    do_reset();
    repeat (3) step(1, 0, '0, 0, 0);
    step(1, 1, 9'h040, 0, 0);
    repeat (10) step(1, 0, '0, 0, 1);
    check_eq("s3_first", dget(0), 32'h40);
    check_eq("s3_second", dget(1), 32'h44);

    // Redirect coinciding with a response and a pop.
    do_reset();
    repeat (5) step(1, 0, '0, 0, 1);
    step(1, 1, 9'h080, 0, 1);
    check_eq("s4_empty", 32'(out_valid), 32'd0);
    check_eq("s4_addr",  32'(imem_addr), 32'h80);
    repeat (8) step(1, 0, '0, 0, 1);
    check_eq("s4_first", dget(0), 32'h80);

    // Halt with three entries queued, then resume via redirect.
    do_reset();
    repeat (4) step(0, 0, '0, 0, 1);
    step(0, 0, '0, 1, 1);
    req_mark = req_cnt;
    repeat (6) step(1, 0, '0, 1, 1);
    check_eq("s5_no_req", 32'(req_cnt - req_mark), 32'd0);
    check_eq("s5_ndeliv", 32'(deliv.size()), 32'd3);
    for (int i = 0; i < 3; i++) check_eq("s5_pc_seq", dget(i), 32'(4 * i));
    step(1, 1, 9'h010, 0, 1);
    repeat (6) step(1, 0, '0, 0, 1);
    check_eq("s5_resume", dget(0), 32'h10);

    // PC wrap at 2^PC_W.
    do_reset();
    step(1, 0, '0, 0, 1);
    step(1, 1, 9'h1FC, 0, 1);
    check_eq("s6_addr_1fc", 32'(imem_addr), 32'h1FC);
    step(1, 0, '0, 0, 1);
    check_eq("s6_addr_wrap", 32'(imem_addr), 32'h000);
    repeat (6) step(1, 0, '0, 0, 1);
    check_eq("s6_pc0", dget(0), 32'h1FC);
    check_eq("s6_pc1", dget(1), 32'h000);

    // Random traffic with a mid-run reset.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, PC_W'($urandom),
           $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
